// File: rtl/fixed_point_pkg.sv
// Shared Q4.4 fixed-point constants and control state encoding
// for the sequential multiplier and divider.
package fixed_point_pkg;

    localparam int WIDTH = 8;
    localparam int FRAC  = 4;

    localparam logic [WIDTH-1:0] QMAX = 8'h7F;
    localparam logic [WIDTH-1:0] QMIN = 8'h80;
    localparam logic [WIDTH-1:0] QONE = 8'h10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINAL
    } fp_state_e;

endpackage

// File: rtl/seq_mul_round_sat.sv
// Round-half-away-from-zero, sign restore and saturation of an
// unsigned double-width magnitude down to a signed Q4.4 result.
import fixed_point_pkg::*;

module seq_mul_round_sat (
    input  logic [2*WIDTH+1:0] acc,
    input  logic               sign,
    output logic [WIDTH-1:0]   product,
    output logic               error
);

    localparam int AW = 2 * WIDTH + 2;

    localparam logic [AW-1:0] HALF    = AW'(1) << (FRAC - 1);
    localparam logic [AW-1:0] POS_LIM = AW'((1 << (WIDTH - 1)) - 1);
    localparam logic [AW-1:0] NEG_LIM = AW'(1 << (WIDTH - 1));

    logic [AW-1:0] mag;

    always_comb begin
        mag     = (acc + HALF) >> FRAC;
        product = sign ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
        error   = 1'b0;
        // Negative side allows one extra step: -2^(WIDTH-1) is exact.
        if (!sign && (mag > POS_LIM)) begin
            product = {1'b0, {(WIDTH-1){1'b1}}};
            error   = 1'b1;
        end else if (sign && (mag > NEG_LIM)) begin
            product = {1'b1, {(WIDTH-1){1'b0}}};
            error   = 1'b1;
        end
    end

endmodule

// File: rtl/seq_multiplier_q4_4.sv
// Sequential signed Q4.4 multiplier: radix-2 shift-add on magnitudes,
// then round, sign restore and saturate. Same handshake as the divider.
import fixed_point_pkg::*;

module seq_multiplier_q4_4 (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product,
    output logic             valid,
    output logic             error,
    output logic             busy
);

    localparam int AW = 2 * WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    fp_state_e        state_q, state_d;
    logic             sign_q, sign_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   b_q, b_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             error_q, error_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]   a_ext, b_ext;
    logic [WIDTH:0]   a_abs, b_abs;
    logic [WIDTH-1:0] rs_product;
    logic             rs_error;

    // One extra bit so that |most negative| stays exact.
    assign a_ext = {multiplicand[WIDTH-1], multiplicand};
    assign b_ext = {multiplier[WIDTH-1], multiplier};
    assign a_abs = a_ext[WIDTH] ? -a_ext : a_ext;
    assign b_abs = b_ext[WIDTH] ? -b_ext : b_ext;

    seq_mul_round_sat u_round_sat (
        .acc     (acc_q),
        .sign    (sign_q),
        .product (rs_product),
        .error   (rs_error)
    );

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        error_d   = error_q;
        valid_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    sign_d  = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                    a_d     = a_abs;
                    b_d     = b_abs;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                if (b_q[0]) begin
                    acc_d = acc_q + (AW'(a_q) << cnt_q);
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                product_d = rs_product;
                error_d   = rs_error;
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            error_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            error_q   <= error_d;
            valid_q   <= valid_d;
        end
    end

    assign product = product_q;
    assign error   = error_q;
    assign valid   = valid_q;
    assign busy    = (state_q != IDLE) || valid_q;

endmodule

// File: tb/tb_seq_multiplier_q4_4.sv
// Scoreboard bench for the sequential Q4.4 multiplier: directed
// corner cases plus random operands against an integer-arithmetic model.
module tb_seq_multiplier_q4_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b1;
    logic [7:0] mcand = 8'h20;
    logic [7:0] mplier = 8'h10;
    logic [7:0] product;
    logic       valid;
    logic       error;
    logic       busy;

    seq_multiplier_q4_4 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .product      (product),
        .valid        (valid),
        .error        (error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] p;
        logic       e;
        int         c;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Plain integer product in 2^-8 units, rounded to 2^-4 units.
    function automatic void model(input logic [7:0] a,
                                  input logic [7:0] b,
                                  output logic [7:0] p,
                                  output logic e);
        int prod, mag, m, r;
        prod = int'($signed(a)) * int'($signed(b));
        mag  = (prod < 0) ? -prod : prod;
        m    = (mag + 8) / 16;
        r    = (prod < 0) ? -m : m;
        if (r > 127) begin
            p = 8'h7F;
            e = 1'b1;
        end else if (r < -128) begin
            p = 8'h80;
            e = 1'b1;
        end else begin
            p = r[7:0];
            e = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got valid=1 expected 0 (t=%0t)",
                         $time);
            end else begin
                cur = sbq.pop_front();
                check("product", product, cur.p);
                check("error", error, cur.e);
                check("latency", cyc - cur.c, 9);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            tick(1);
            n++;
        end
        check("busy_idle", busy, 0);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] p, input logic e);
        exp_t x;
        wait_idle();
        mcand = a;
        mplier = b;
        start = 1'b1;
        tick(1);
        x.p = p;
        x.e = e;
        x.c = cyc;
        sbq.push_back(x);
        check("busy_after_start", busy, 1);
        start = 1'b0;
        mcand = 8'($urandom);
        mplier = 8'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check("drain", sbq.size(), 0);
    endtask

    logic [7:0] da[12] = '{8'h20, 8'hE0, 8'h18, 8'hF0, 8'h08, 8'h01,
                           8'hFF, 8'h40, 8'h80, 8'h80, 8'h00, 8'h7F};
    logic [7:0] db[12] = '{8'h10, 8'h20, 8'hE8, 8'hE0, 8'h08, 8'h08,
                           8'h08, 8'h40, 8'hF0, 8'h10, 8'h5A, 8'h80};
    logic [7:0] dp[12] = '{8'h20, 8'hC0, 8'hDC, 8'h20, 8'h04, 8'h01,
                           8'hFF, 8'h7F, 8'h7F, 8'h80, 8'h00, 8'h80};
    logic       de[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [7:0] ra, rb, rp;
        logic       re;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_product", product, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        tick(15);
        check("idle_busy", busy, 0);

        // Each issue waits for busy low, so starts land the cycle after valid.
        for (int i = 0; i < 12; i++) begin
            issue(da[i], db[i], dp[i], de[i]);
        end
        wait_drain();

        issue(8'h18, 8'h28, 8'h3C, 1'b0);
        tick(3);
        start = 1'b1;
        mcand = 8'h40;
        mplier = 8'h40;
        tick(1);
        start = 1'b0;
        wait_drain();
        tick(12);

        issue(8'h30, 8'h30, 8'h7F, 1'b1);
        tick(4);
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("abort_product", product, 8'h00);
        check("abort_valid", valid, 0);
        check("abort_error", error, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(15);
        check("abort_idle_busy", busy, 0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            model(ra, rb, rp, re);
            issue(ra, rb, rp, re);
        end
        wait_drain();
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
